pulse_stretcher: RTL and testbench

Converts single-cycle enable events (as produced by the push-button one-pulse stage) into visible, fixed-length output levels for LEDs or slow downstream logic. Each accepted event produces one high window of HIGH_CYCLES clocks followed by a low gap of GAP_CYCLES clocks. Events arriving while a window is in progress are counted and replayed in order, so no press is lost unless the pending counter saturates. The block sits between the one-pulse stage and the lab-board outputs.

---
 rtl/pulse_stretcher.sv | 116 +++++++++++
 tb/tb_pulse_stretcher.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into HIGH_CYCLES-wide windows separated by GAP_CYCLES.
// Define PULSE_RETRIGGER_EN to let events during a window extend it instead of queueing.
module pulse_stretcher #(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulseIn,
    output logic              stretchOut,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAXC = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_GAP
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              stretch_q;
    logic              pend_full;
    logic              cnt_zero;
    logic [PEND_W-1:0] enq_pending;
    logic              enq_overflow;

    // Result of queueing one event: a full counter drops it and flags overflow.
    always_comb begin
        pend_full    = (pending == PEND_MAX);
        cnt_zero     = (cnt == '0);
        enq_pending  = pend_full ? pending : pending + PEND_ONE;
        enq_overflow = overflow | pend_full;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            stretch_q <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pulseIn) begin
                        state     <= S_HIGH;
                        cnt       <= HIGH_LOAD;
                        stretch_q <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        state     <= S_GAP;
                        cnt       <= GAP_LOAD;
                        stretch_q <= 1'b0;
                    end
`ifdef PULSE_RETRIGGER_EN
                    if (pulseIn) begin
                        state     <= S_HIGH;
                        cnt       <= HIGH_LOAD;
                        stretch_q <= 1'b1;
                    end
`else
                    if (pulseIn) begin
                        pending  <= enq_pending;
                        overflow <= enq_overflow;
                    end
`endif
                end
                S_GAP: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - CNT_ONE;
                        if (pulseIn) begin
                            pending  <= enq_pending;
                            overflow <= enq_overflow;
                        end
                    end else if (pending != '0 || pulseIn) begin
                        state     <= S_HIGH;
                        cnt       <= HIGH_LOAD;
                        stretch_q <= 1'b1;
                        // A same-cycle event replaces the consumed one in the queue.
                        if (pending != '0 && !pulseIn) begin
                            pending <= pending - PEND_ONE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cnt       <= '0;
                    stretch_q <= 1'b0;
                end
            endcase
        end
    end

    assign stretchOut = stretch_q;
    assign busy       = (state != S_IDLE) || (pending != '0);

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (HIGH_CYCLES=4, GAP_CYCLES=2, PEND_W=2).
// Vector table plus hand sequences for saturation, async reset and retrigger.
module tb_pulse_stretcher;

    logic       clk;
    logic       reset;
    logic       pulseIn;
    logic       stretchOut;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    pulse_stretcher #(
        .HIGH_CYCLES(4),
        .GAP_CYCLES (2),
        .PEND_W     (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pulseIn   (pulseIn),
        .stretchOut(stretchOut),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       pulse;
        logic       s;
        logic       b;
        logic [1:0] p;
        logic       o;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic pl, input logic s,
                       input logic b, input logic [1:0] p, input logic o);
        vec_t v;
        v.pulse = pl;
        v.s     = s;
        v.b     = b;
        v.p     = p;
        v.o     = o;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic p);
        @(negedge clk);
        pulseIn = p;
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input string tag, input int first, input int last);
        for (int i = first; i < last; i++) begin
            step(vecs[i].pulse);
            chk($sformatf("%s[%0d].stretch", tag, i), int'(stretchOut), int'(vecs[i].s));
            chk($sformatf("%s[%0d].busy", tag, i), int'(busy), int'(vecs[i].b));
            chk($sformatf("%s[%0d].pending", tag, i), int'(pending), int'(vecs[i].p));
            chk($sformatf("%s[%0d].overflow", tag, i), int'(overflow), int'(vecs[i].o));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 60) begin
            step(1'b0);
            n++;
        end
        chk({tag, ".idle_reached"}, int'(busy), 0);
    endtask

    initial begin
        int windows;
        int highs;
        int n;
        logic prev;

        // single event: rows 0..7
        add(1, 1, 1, 1, 0, 0);
        add(3, 0, 1, 1, 0, 0);
        add(2, 0, 0, 1, 0, 0);
        add(2, 0, 0, 0, 0, 0);
        // burst of three: rows 8..26
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 1, 0);
        add(1, 1, 1, 1, 2, 0);
        add(1, 0, 1, 1, 2, 0);
        add(2, 0, 0, 1, 2, 0);
        add(4, 0, 1, 1, 1, 0);
        add(2, 0, 0, 1, 1, 0);
        add(4, 0, 1, 1, 0, 0);
        add(2, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        // event on the final gap cycle with one queued: rows 27..45
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 1, 1, 1, 0);
        add(2, 0, 1, 1, 1, 0);
        add(2, 0, 0, 1, 1, 0);
        add(1, 1, 1, 1, 1, 0);
        add(3, 0, 1, 1, 1, 0);
        add(2, 0, 0, 1, 1, 0);
        add(4, 0, 1, 1, 0, 0);
        add(2, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0);

        reset   = 1'b0;
        pulseIn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.stretch", int'(stretchOut), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.pending", int'(pending), 0);
        chk("rst.overflow", int'(overflow), 0);
        @(negedge clk);
        reset = 1'b1;

        run_rows("single", 0, 8);
        run_rows("burst", 8, 27);
        run_rows("simul", 27, 46);

        // six back-to-back events saturate the 2-bit queue
        windows = 0;
        prev    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            if (stretchOut && !prev) windows++;
            prev = stretchOut;
        end
        chk("sat.pending", int'(pending), 3);
        chk("sat.overflow", int'(overflow), 1);
        n = 0;
        while (busy && n < 60) begin
            step(1'b0);
            if (stretchOut && !prev) windows++;
            prev = stretchOut;
            n++;
        end
        chk("sat.idle_reached", int'(busy), 0);
        chk("sat.windows", windows, 4);
        chk("sat.overflow_sticky", int'(overflow), 1);
        chk("sat.pending_end", int'(pending), 0);

        // asynchronous reset in the middle of a window with two queued
        step(1'b1);
        step(1'b1);
        step(1'b1);
        chk("mid.pending", int'(pending), 2);
        chk("mid.stretch", int'(stretchOut), 1);
        #2;
        reset   = 1'b0;
        pulseIn = 1'b0;
        #1;
        chk("arst.stretch", int'(stretchOut), 0);
        chk("arst.busy", int'(busy), 0);
        chk("arst.pending", int'(pending), 0);
        chk("arst.overflow", int'(overflow), 0);
        @(posedge clk);
        #1;
        chk("arst.hold_stretch", int'(stretchOut), 0);
        @(negedge clk);
        reset   = 1'b1;
        pulseIn = 1'b1;
        @(posedge clk);
        #1;
        chk("rel.first_edge_stretch", int'(stretchOut), 1);
        chk("rel.first_edge_pending", int'(pending), 0);
        run_rows("post_rst", 1, 8);

        // event during the third high cycle
        highs = 0;
        step(1'b1);
        if (stretchOut) highs++;
        step(1'b0);
        if (stretchOut) highs++;
        step(1'b1);
        if (stretchOut) highs++;
`ifdef PULSE_RETRIGGER_EN
        chk("retrig.pending", int'(pending), 0);
`else
        chk("retrig.pending", int'(pending), 1);
`endif
        n = 0;
        while (stretchOut && n < 20) begin
            step(1'b0);
            if (stretchOut) highs++;
            n++;
        end
`ifdef PULSE_RETRIGGER_EN
        chk("retrig.high_len", highs, 6);
`else
        chk("retrig.high_len", highs, 4);
`endif
        wait_idle("retrig");
        chk("retrig.pending_end", int'(pending), 0);
        chk("retrig.overflow", int'(overflow), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
